// File: rtl/ex_mem_stage.sv
// Execute/memory pipeline stage: turns execute results into register writebacks,
// single-outstanding load/store requests and one-cycle fetch redirect pulses.
module ex_mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ix_valid_p1,
    input  logic [15:0] rd_p1,
    input  logic [15:0] st_data_p1,
    input  logic        ld_p1,
    input  logic        st_p1,
    input  logic        wr_en_p1,
    input  logic [2:0]  wr_reg_p1,
    input  logic        br_taken_p1,
    input  logic [15:0] pc_nxt_p1,
    input  logic        mem_ready,
    input  logic        mem_rdata_valid,
    input  logic [15:0] mem_rdata,
    output logic        stall_p1,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        wb_valid,
    output logic [2:0]  wb_reg,
    output logic [15:0] wb_data,
    output logic        redirect_valid,
    output logic [15:0] redirect_pc
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    state_t      state_q, state_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        wb_valid_q, wb_valid_d;
    logic [2:0]  wb_reg_q, wb_reg_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [15:0] redirect_pc_q, redirect_pc_d;
    logic        accept;

    // Decoding straight from the state flop lets reset drop mem_req and stall immediately.
    assign stall_p1 = (state_q == REQ) || (state_q == WAIT);
    assign mem_req  = (state_q == REQ);
    assign accept   = ix_valid_p1 && !stall_p1;

    always_comb begin
        state_d          = state_q;
        mem_we_d         = mem_we_q;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;
        wb_valid_d       = 1'b0;
        wb_reg_d         = wb_reg_q;
        wb_data_d        = wb_data_q;
        redirect_valid_d = accept && br_taken_p1;
        redirect_pc_d    = redirect_pc_q;

        if (accept && br_taken_p1) begin
            redirect_pc_d = pc_nxt_p1;
        end

        case (state_q)
            IDLE, WB: begin
                state_d = IDLE;
                if (accept) begin
                    wb_reg_d = wr_reg_p1;
                    if (ld_p1 || st_p1) begin
                        // A load+store combination is issued as a store.
                        state_d     = REQ;
                        mem_we_d    = st_p1;
                        mem_addr_d  = rd_p1;
                        mem_wdata_d = st_data_p1;
                    end else begin
                        state_d    = WB;
                        wb_valid_d = wr_en_p1;
                        wb_data_d  = rd_p1;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    if (mem_we_q) begin
                        state_d = IDLE;
                    end else if (mem_rdata_valid) begin
                        state_d    = WB;
                        wb_valid_d = 1'b1;
                        wb_data_d  = mem_rdata;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rdata_valid) begin
                    state_d    = WB;
                    wb_valid_d = 1'b1;
                    wb_data_d  = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= 16'h0000;
            mem_wdata_q      <= 16'h0000;
            wb_valid_q       <= 1'b0;
            wb_reg_q         <= 3'd0;
            wb_data_q        <= 16'h0000;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 16'h0000;
        end else begin
            state_q          <= state_d;
            mem_we_q         <= mem_we_d;
            mem_addr_q       <= mem_addr_d;
            mem_wdata_q      <= mem_wdata_d;
            wb_valid_q       <= wb_valid_d;
            wb_reg_q         <= wb_reg_d;
            wb_data_q        <= wb_data_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign wb_valid       = wb_valid_q;
    assign wb_reg         = wb_reg_q;
    assign wb_data        = wb_data_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed plus randomized checks of ex_mem_stage against a transaction-level model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ix_valid_p1, ld_p1, st_p1, wr_en_p1, br_taken_p1;
    logic [15:0] rd_p1, st_data_p1, pc_nxt_p1, mem_rdata;
    logic [2:0]  wr_reg_p1;
    logic        mem_ready, mem_rdata_valid;
    logic        stall_p1, mem_req, mem_we, wb_valid, redirect_valid;
    logic [15:0] mem_addr, mem_wdata, wb_data, redirect_pc;
    logic [2:0]  wb_reg;

    int n_cmp = 0;
    int n_err = 0;

    // Model: at most one memory op in flight; "granted" once memory took the request.
    bit          m_busy, m_granted, m_store;
    logic [15:0] m_addr, m_wdata;
    logic [2:0]  m_reg;
    bit          e_wb_valid, e_rv;
    logic [2:0]  e_wb_reg;
    logic [15:0] e_wb_data, e_rpc;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .rst(rst),
        .ix_valid_p1(ix_valid_p1), .rd_p1(rd_p1), .st_data_p1(st_data_p1),
        .ld_p1(ld_p1), .st_p1(st_p1), .wr_en_p1(wr_en_p1), .wr_reg_p1(wr_reg_p1),
        .br_taken_p1(br_taken_p1), .pc_nxt_p1(pc_nxt_p1),
        .mem_ready(mem_ready), .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .stall_p1(stall_p1), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_granted = 0; m_store = 0;
        e_wb_valid = 0; e_rv = 0;
    endtask

    task automatic model_update();
        bit accept;
        accept     = ix_valid_p1 && !m_busy;
        e_wb_valid = 0;
        e_rv       = accept && br_taken_p1;
        if (e_rv) e_rpc = pc_nxt_p1;
        if (m_busy) begin
            if (!m_granted) begin
                if (mem_ready) begin
                    if (m_store) m_busy = 0;
                    else if (mem_rdata_valid) begin
                        m_busy = 0; e_wb_valid = 1; e_wb_reg = m_reg; e_wb_data = mem_rdata;
                    end else m_granted = 1;
                end
            end else if (mem_rdata_valid) begin
                m_busy = 0; e_wb_valid = 1; e_wb_reg = m_reg; e_wb_data = mem_rdata;
            end
        end else if (accept) begin
            if (ld_p1 || st_p1) begin
                m_busy = 1; m_granted = 0; m_store = st_p1;
                m_addr = rd_p1; m_wdata = st_data_p1; m_reg = wr_reg_p1;
            end else begin
                e_wb_valid = wr_en_p1; e_wb_reg = wr_reg_p1; e_wb_data = rd_p1;
            end
        end
    endtask

    task automatic check_all();
        chk("stall_p1", {15'd0, stall_p1}, {15'd0, m_busy});
        chk("mem_req", {15'd0, mem_req}, {15'd0, m_busy && !m_granted});
        if (m_busy && !m_granted) begin
            chk("mem_we", {15'd0, mem_we}, {15'd0, m_store});
            chk("mem_addr", mem_addr, m_addr);
            if (m_store) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("wb_valid", {15'd0, wb_valid}, {15'd0, e_wb_valid});
        if (e_wb_valid) begin
            chk("wb_reg", {13'd0, wb_reg}, {13'd0, e_wb_reg});
            chk("wb_data", wb_data, e_wb_data);
        end
        chk("redirect_valid", {15'd0, redirect_valid}, {15'd0, e_rv});
        if (e_rv) chk("redirect_pc", redirect_pc, e_rpc);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        ix_valid_p1 = 0; ld_p1 = 0; st_p1 = 0; wr_en_p1 = 0; br_taken_p1 = 0;
        rd_p1 = 0; st_data_p1 = 0; pc_nxt_p1 = 0; wr_reg_p1 = 0;
        mem_ready = 0; mem_rdata_valid = 0; mem_rdata = 0;
    endtask

    task automatic op(input bit ld, input bit st, input bit we, input logic [2:0] r,
                      input logic [15:0] rd, input logic [15:0] sd,
                      input bit br, input logic [15:0] pc);
        ix_valid_p1 = 1; ld_p1 = ld; st_p1 = st; wr_en_p1 = we; wr_reg_p1 = r;
        rd_p1 = rd; st_data_p1 = sd; br_taken_p1 = br; pc_nxt_p1 = pc;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".stall"}, {15'd0, stall_p1}, 16'd0);
        chk({tag, ".mem_req"}, {15'd0, mem_req}, 16'd0);
        chk({tag, ".mem_we"}, {15'd0, mem_we}, 16'd0);
        chk({tag, ".mem_addr"}, mem_addr, 16'd0);
        chk({tag, ".mem_wdata"}, mem_wdata, 16'd0);
        chk({tag, ".wb_valid"}, {15'd0, wb_valid}, 16'd0);
        chk({tag, ".wb_reg"}, {13'd0, wb_reg}, 16'd0);
        chk({tag, ".wb_data"}, wb_data, 16'd0);
        chk({tag, ".redirect_valid"}, {15'd0, redirect_valid}, 16'd0);
        chk({tag, ".redirect_pc"}, redirect_pc, 16'd0);
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        model_reset();
        #1;
        check_all_zero("reset");
        @(negedge clk); @(negedge clk);
        rst = 1;
        check_all();

        // ALU op writes back next cycle, never stalls
        op(0, 0, 1, 3'd3, 16'h1234, 16'h0, 0, 16'h0); step();
        idle_inputs(); step();

        // Load: ready on third request cycle, data three cycles later
        op(1, 0, 1, 3'd5, 16'h0040, 16'h0, 0, 16'h0); step();
        idle_inputs(); step(); step();
        mem_ready = 1; step();
        mem_ready = 0; step(); step();
        mem_rdata_valid = 1; mem_rdata = 16'hBEEF; step();
        idle_inputs(); step();

        // Store accepted immediately: no writeback
        op(0, 1, 0, 3'd1, 16'h0010, 16'h00FF, 0, 16'h0); step();
        idle_inputs(); mem_ready = 1; step();
        idle_inputs(); step();

        // Load with ready and data together skips WAIT
        op(1, 0, 1, 3'd6, 16'h0020, 16'h0, 0, 16'h0); step();
        idle_inputs(); mem_ready = 1; mem_rdata_valid = 1; mem_rdata = 16'h0007; step();
        idle_inputs(); step();

        // Load+store together behaves as a store
        op(1, 1, 1, 3'd2, 16'h0030, 16'hA5A5, 0, 16'h0); step();
        idle_inputs(); mem_ready = 1; mem_rdata_valid = 1; mem_rdata = 16'h5555; step();
        idle_inputs(); step();

        // Branch redirect, then back-to-back ALU ops
        op(0, 0, 0, 3'd0, 16'h0, 16'h0, 1, 16'h0100); step();
        op(0, 0, 1, 3'd1, 16'h1111, 16'h0, 0, 16'h0); step();
        op(0, 0, 1, 3'd2, 16'h2222, 16'h0, 0, 16'h0); step();
        op(0, 0, 1, 3'd4, 16'h4444, 16'h0, 0, 16'h0); step();
        idle_inputs(); step();

        // Reset mid-WAIT abandons the load
        op(1, 0, 1, 3'd7, 16'h0050, 16'h0, 0, 16'h0); step();
        idle_inputs(); mem_ready = 1; step();
        idle_inputs(); step();
        #2 rst = 0;
        #1 check_all_zero("rst_mid_wait");
        model_reset();
        @(negedge clk); rst = 1;
        mem_rdata_valid = 1; mem_rdata = 16'hDEAD; step();
        idle_inputs(); step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            ix_valid_p1     = ($urandom_range(0, 3) != 0);
            ld_p1           = ($urandom_range(0, 2) == 0);
            st_p1           = ($urandom_range(0, 3) == 0);
            wr_en_p1        = $urandom_range(0, 1);
            wr_reg_p1       = 3'($urandom);
            rd_p1           = 16'($urandom);
            st_data_p1      = 16'($urandom);
            br_taken_p1     = ($urandom_range(0, 3) == 0);
            pc_nxt_p1       = 16'($urandom);
            mem_ready       = $urandom_range(0, 1);
            mem_rdata_valid = ($urandom_range(0, 2) == 0);
            mem_rdata       = 16'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
